// File: rtl/data_mem_responder.sv
// Load/store responder: word-organised data SRAM behind a valid/ready request
// and response handshake, with wait states, byte-lane steering, sign/zero
// extension and alignment/illegal-code checks.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_func_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_misaligned_o,
  output logic        rsp_illegal_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  localparam logic [3:0] F_NOP = 4'd0, F_LW = 4'd1, F_LH = 4'd2, F_LB = 4'd3,
                         F_LHU = 4'd4, F_LBU = 4'd5, F_SW = 4'd6, F_SH = 4'd7,
                         F_SB = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          r_state, w_next;
  logic [3:0]      r_func, r_cnt;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_mis, r_ill;
  logic [31:0]     r_mem [DEPTH];

  logic            w_idle, w_accept, w_access, w_we;
  logic [3:0]      w_func;
  logic [AW-1:0]   w_addr;
  logic [31:0]     w_wdata, w_word, w_load, w_lane_data;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [3:0]      w_be;
  logic            w_is_word, w_is_half, w_is_store, w_illegal, w_nop, w_misal, w_ok;
  logic            w_unused_addr;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = req_valid_i & w_idle;

  // In IDLE the live request is decoded (zero-latency access and routing);
  // once accepted, the captured copy drives everything.
  assign w_func  = w_idle ? req_func_i        : r_func;
  assign w_addr  = w_idle ? req_addr_i[AW-1:0] : r_addr;
  assign w_wdata = w_idle ? req_wdata_i       : r_wdata;

  // Upper address bits are dropped so addresses wrap modulo memory depth.
  assign w_unused_addr = ^req_addr_i[31:AW];

  assign w_is_word  = (w_func == F_LW) || (w_func == F_SW);
  assign w_is_half  = (w_func == F_LH) || (w_func == F_LHU) || (w_func == F_SH);
  assign w_is_store = (w_func == F_SW) || (w_func == F_SH) || (w_func == F_SB);
  assign w_illegal  = (w_func > F_SB);
  assign w_nop      = (w_func == F_NOP);
  assign w_misal    = (w_is_word && (w_addr[1:0] != 2'b00)) || (w_is_half && w_addr[0]);
  assign w_ok       = !w_illegal && !w_nop && !w_misal;

  // The memory is touched only on the edge that enters RESP for a good access.
  assign w_access = (w_accept && w_ok && (LATENCY == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt == 4'd0));
  assign w_we     = w_access && w_is_store;

  assign w_idx  = w_addr[AW-1:2];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  // Load steering and extension
  always_comb begin
    w_load = 32'd0;
    case (w_func)
      F_LW:    w_load = w_word;
      F_LH:    w_load = {{16{w_half[15]}}, w_half};
      F_LHU:   w_load = {16'd0, w_half};
      F_LB:    w_load = {{24{w_byte[7]}}, w_byte};
      F_LBU:   w_load = {24'd0, w_byte};
      default: w_load = 32'd0;
    endcase
  end

  // Store byte enables; data is replicated so every enabled lane sees its byte
  always_comb begin
    w_be        = 4'b0000;
    w_lane_data = w_wdata;
    case (w_func)
      F_SW: w_be = 4'b1111;
      F_SH: begin
        w_be        = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_data = {2{w_wdata[15:0]}};
      end
      F_SB: begin
        w_be        = 4'b0001 << w_addr[1:0];
        w_lane_data = {4{w_wdata[7:0]}};
      end
      default: w_be = 4'b0000;
    endcase
  end

  // SRAM write port (contents deliberately not reset)
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = (w_ok && (LATENCY > 0)) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (rsp_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Request capture, wait counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func  <= F_NOP;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_mis   <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_func  <= req_func_i;
        r_addr  <= req_addr_i[AW-1:0];
        r_wdata <= req_wdata_i;
        r_cnt   <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if ((w_next == S_RESP) && (r_state != S_RESP)) begin
        r_rdata <= w_access ? w_load : 32'd0;
        r_mis   <= !w_illegal && w_misal;
        r_ill   <= w_illegal;
      end else if ((r_state == S_RESP) && rsp_ready_i) begin
        r_rdata <= 32'd0;
        r_mis   <= 1'b0;
        r_ill   <= 1'b0;
      end
    end
  end

  assign req_ready_o      = w_idle;
  assign rsp_valid_o      = (r_state == S_RESP);
  assign rsp_rdata_o      = r_rdata;
  assign rsp_misaligned_o = r_mis;
  assign rsp_illegal_o    = r_ill;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_data_mem_responder;

  localparam int AWID = 10;
  localparam int LAT  = 2;

  localparam logic [3:0] NOP = 4'd0, LW = 4'd1, LH = 4'd2, LB = 4'd3,
                         LHU = 4'd4, LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready_o;
  logic [3:0]  req_func;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid_o, rsp_ready;
  logic [31:0] rsp_rdata_o;
  logic        rsp_misaligned_o, rsp_illegal_o;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [logic [31:0]];

  data_mem_responder #(.ADDR_WIDTH(AWID), .LATENCY(LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_func_i       (req_func),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_rdata_o      (rsp_rdata_o),
    .rsp_misaligned_o (rsp_misaligned_o),
    .rsp_illegal_o    (rsp_illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] rd, input logic mis, input logic ill, input int lat);
    exp_t e;
    e.rdata = rd; e.mis = mis; e.ill = ill; e.lat = lat;
    sb.push_back(e);
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic send(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_func = f; req_addr = a; req_wdata = d;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for a response, counting cycles from the acceptance edge.
  task automatic get_rsp(input string tag);
    int   lat = 0;
    exp_t e;
    do begin @(negedge clk); lat++; end while (!rsp_valid_o && lat < 40);
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      chk({tag, "_rdata"}, rsp_rdata_o, e.rdata);
      chk({tag, "_mis"}, 32'(rsp_misaligned_o), 32'(e.mis));
      chk({tag, "_ill"}, 32'(rsp_illegal_o), 32'(e.ill));
    end
  endtask

  // Full transaction with rsp_ready held high; checks the handshake cleanup.
  task automatic txn(input string tag, input logic [3:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic em,
                     input logic ei, input int el);
    send(f, a, d);
    push(er, em, ei, el);
    req_valid = 1'b0; req_func = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    get_rsp(tag);
    @(negedge clk);
    chk({tag, "_hs_valid"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, "_hs_rdata"}, rsp_rdata_o, 32'd0);
    chk({tag, "_hs_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addrs[6];
    rst_n = 1'b0; req_valid = 1'b0; req_func = NOP; req_addr = 32'd0;
    req_wdata = 32'd0; rsp_ready = 1'b1;
    #12;
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_mis", 32'(rsp_misaligned_o), 32'd0);
    chk("rst_ill", 32'(rsp_illegal_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Word store/load and extensions
    txn("sw",    SW,  32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, LAT + 1);
    txn("lw",    LW,  32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, LAT + 1);
    txn("lb103", LB,  32'h103, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b0, LAT + 1);
    txn("lbu103",LBU, 32'h103, 32'h0, 32'h000000DE, 1'b0, 1'b0, LAT + 1);
    txn("lh102", LH,  32'h102, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b0, LAT + 1);
    txn("lhu102",LHU, 32'h102, 32'h0, 32'h0000DEAD, 1'b0, 1'b0, LAT + 1);
    txn("lb100", LB,  32'h100, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b0, LAT + 1);

    // Partial stores and address wrap
    txn("sh102", SH,  32'h102, 32'h00001234, 32'h0, 1'b0, 1'b0, LAT + 1);
    txn("sb101", SB,  32'h101, 32'h0000AA55, 32'h0, 1'b0, 1'b0, LAT + 1);
    txn("lw_part", LW, 32'h100, 32'h0, 32'h123455EF, 1'b0, 1'b0, LAT + 1);
    txn("lw_wrap", LW, 32'h100 + 4 * (2 ** AWID), 32'h0, 32'h123455EF, 1'b0, 1'b0, LAT + 1);

    // Errors respond one cycle after acceptance
    txn("lw_mis",  LW,    32'h101, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    txn("sh_mis",  SH,    32'h103, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, 1);
    txn("lw_after_mis", LW, 32'h100, 32'h0, 32'h123455EF, 1'b0, 1'b0, LAT + 1);
    txn("illegal", 4'd12, 32'h101, 32'h0, 32'h0, 1'b0, 1'b1, 1);
    txn("nop",     NOP,   32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1);
    txn("lh_odd",  LHU,   32'h101, 32'h0, 32'h0, 1'b1, 1'b0, 1);

    // Backpressure: second request held valid until the first response drains
    rsp_ready = 1'b0;
    send(LW, 32'h100, 32'h0);
    push(32'h123455EF, 1'b0, 1'b0, LAT + 1);
    req_func = LBU; req_addr = 32'h101;
    get_rsp("bp");
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_hold_rdata", rsp_rdata_o, 32'h123455EF);
      chk("bp_hold_ready", 32'(req_ready_o), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp_drain_ready", 32'(req_ready_o), 32'd1);
    @(posedge clk); #1;
    push(32'h00000055, 1'b0, 1'b0, LAT + 1);
    req_valid = 1'b0;
    get_rsp("bp2");
    @(negedge clk);
    chk("bp2_hs_ready", 32'(req_ready_o), 32'd1);

    // Reset during WAIT discards the pending store
    txn("sw200_zero", SW, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, LAT + 1);
    send(SW, 32'h200, 32'h11111111);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wait_ready", 32'(req_ready_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
    chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_rdata", rsp_rdata_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    txn("lw200", LW, 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, LAT + 1);

    // Random word traffic against a bench-side memory model
    for (int i = 0; i < 6; i++) begin
      logic [31:0] d;
      addrs[i] = {20'd0, 2'b01, 8'($urandom), 2'b00};
      d = $urandom;
      model[addrs[i]] = d;
      txn("rnd_sw", SW, addrs[i], d, 32'h0, 1'b0, 1'b0, LAT + 1);
    end
    for (int i = 0; i < 6; i++)
      txn("rnd_lw", LW, addrs[i], 32'h0, model[addrs[i]], 1'b0, 1'b0, LAT + 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the load/store request interface driven by the pipeline's memory stage.
- Accepts one request at a time: load/store function code (NOP, LW, LH, LB, LHU, LBU, SW, SH, SB), byte address and store data.
- Models a word-organised data SRAM with configurable wait states.
- Performs byte-lane steering, sign/zero extension and alignment checks, then returns a response under valid/ready handshake.

Parameters:
- ADDR_WIDTH, 10, word-address bits; memory depth = 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between acceptance and memory access (0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_func_i  input  4  function code: NOP=0, LW=1, LH=2, LB=3, LHU=4, LBU=5, SW=6, SH=7, SB=8; 9..15 illegal.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data; low byte/half used for SB/SH.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  requester accepts response.
- rsp_rdata_o  output  32  load result, extended to 32 bits; 0 for stores/NOP/errors.
- rsp_misaligned_o  output  1  address misaligned for access size.
- rsp_illegal_o  output  1  function code 9..15.

Behaviour:
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_misaligned_o=0, rsp_illegal_o=0, state=IDLE, wait counter=0.
- Memory contents are not reset.
- States:
  - IDLE: req_ready_o=1.
  - WAIT: counting.
  - RESP: rsp_valid_o=1.
- Acceptance: handshake when req_valid_i & req_ready_o. Func, addr and wdata are registered; inputs are ignored afterwards.
- IDLE to WAIT: valid, aligned, non-NOP access with LATENCY>0. Counter loads LATENCY-1 and decrements each cycle. At 0, perform the access and go to RESP.
- IDLE to RESP directly: LATENCY=0 (access performed on the acceptance edge), NOP, misaligned or illegal. Response appears the cycle after acceptance.
- Latency for a normal access: rsp_valid_o asserts LATENCY+1 cycles after acceptance.
- Access timing: the store write and the load read/extension occur on the edge entering RESP. rsp_rdata_o is registered on that edge.
- Word index = req_addr_i[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Alignment rules:
  - Word ops: misaligned if addr[1:0]≠0.
  - Half ops: misaligned if addr[0]=1.
  - Byte ops: never misaligned.
  - Misaligned: no memory write, rdata=0, misaligned=1.
- Illegal code: rsp_illegal_o=1, rdata=0, no write. Alignment is not checked.
- NOP: rdata=0, both flags 0.
- Stores:
  - SW writes all four bytes.
  - SH writes bytes {addr[1],1'b0}+0/+1 with wdata[15:0].
  - SB writes byte addr[1:0] with wdata[7:0].
  - Other bytes are unchanged. Little-endian.
- Loads:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- RESP to IDLE when rsp_ready_i=1. Outputs are held stable while rsp_ready_i=0.
- rsp_valid_o, rdata and flags clear to 0 on the edge leaving RESP.
- No new request is accepted in the same cycle as the response handshake; req_ready_o rises the following cycle.
- Reset asserted mid-operation:
  - Immediate return to reset values.
  - A store still in WAIT is discarded (never written).
  - A store already in RESP has been committed.
- Changes on req_* while not IDLE have no effect.

Test Plan:
- LATENCY=2: SW 0xDEADBEEF @0x100, then LW @0x100 -> rsp_valid 3 cycles after each acceptance; LW rdata=0xDEADBEEF, flags 0.
- Extension on the same word:
  - LB @0x103 -> 0xFFFFFFDE; LBU @0x103 -> 0x000000DE.
  - LH @0x102 -> 0xFFFFDEAD; LHU @0x102 -> 0x0000DEAD; LB @0x100 -> 0xFFFFFFEF.
- Partial stores: SH 0x00001234 @0x102, SB 0xAA55 @0x101, then LW @0x100 -> 0x123455EF. Address wrap: LW @(0x100+4*2**ADDR_WIDTH) -> same value.
- Misalignment and errors:
  - LW @0x101 -> response 1 cycle after acceptance, misaligned=1, rdata=0.
  - SH 0xFFFF @0x103 -> misaligned=1; later LW @0x100 still 0x123455EF.
  - func=12 -> illegal=1, rdata=0.
- Backpressure: hold rsp_ready_i=0 for 4 cycles during an LW response -> rsp_valid/rdata stable, req_ready_o=0. Assert ready -> rsp_valid 0 and req_ready 1 next cycle. A req_valid held throughout is accepted only then.
- Reset: SW 0x11111111 @0x200 with 0x200 previously 0x0; pulse rst_n low during WAIT -> outputs at reset values immediately; subsequent LW @0x200 -> 0x0.
